// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: bus widths, reset vector,
// FSM encoding and PC alignment helper.
package ifu_pkg;

    localparam int PC_W        = 32;
    localparam int DATA_W      = 32;
    localparam int IBUS_ADDR_W = PC_W;
    localparam int IBUS_DATA_W = DATA_W;

    localparam logic [PC_W-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [PC_W-1:0] PC_STEP              = 32'd4;
    localparam logic [PC_W-1:0] ALIGN_MASK           = {{(PC_W-2){1'b1}}, 2'b00};

    typedef enum logic {
        IFU_REQ  = 1'b0,
        IFU_WAIT = 1'b1
    } ifu_state_e;

    // Redirect targets arrive unchecked; fetch always uses a word address.
    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/ifu_skid_buf.sv
// One-entry {pc, instruction} holding register that absorbs a response
// arriving while decode is stalled.
module ifu_skid_buf
    import ifu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic              drain,
    input  logic [PC_W-1:0]   load_pc,
    input  logic [DATA_W-1:0] load_instr,
    output logic              valid,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] instr
);

    logic              valid_reg;
    logic [PC_W-1:0]   pc_reg;
    logic [DATA_W-1:0] instr_reg;

    // Clear (redirect) dominates; load and drain never coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
        end else if (clear) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
        end else if (drain) begin
            valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg    <= '0;
            instr_reg <= '0;
        end else if (load && !clear) begin
            pc_reg    <= load_pc;
            instr_reg <= load_instr;
        end
    end

    assign valid = valid_reg;
    assign pc    = pc_reg;
    assign instr = instr_reg;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: owns the fetch PC, keeps one request outstanding on
// the instruction bus and feeds the IF/ID register, with redirect and kill.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_stall,
    input  logic                   branch_take,
    input  logic [PC_W-1:0]        branch_pc,
    input  logic                   trap_take,
    input  logic [PC_W-1:0]        trap_pc,
    output logic                   ibus_req,
    output logic [IBUS_ADDR_W-1:0] ibus_addr,
    input  logic                   ibus_ready,
    input  logic                   ibus_rvalid,
    input  logic [IBUS_DATA_W-1:0] ibus_rdata,
    output logic                   if2id_valid,
    output logic [PC_W-1:0]        if2id_pc,
    output logic [DATA_W-1:0]      if2id_instruction
);

    ifu_state_e        state_reg, state_next;
    logic [PC_W-1:0]   pc_reg, pc_next;
    logic [PC_W-1:0]   req_pc_reg, req_pc_next;
    logic              kill_reg, kill_next;
    logic              if2id_valid_reg, if2id_valid_next;
    logic [PC_W-1:0]   if2id_pc_reg, if2id_pc_next;
    logic [DATA_W-1:0] if2id_instr_reg, if2id_instr_next;

    logic              redirect;
    logic [PC_W-1:0]   target;
    logic              rsp_in_wait;
    logic              rsp_live;
    logic              handshake;
    logic              deliver;
    logic              skid_load;
    logic              skid_drain;
    logic              skid_valid;
    logic [PC_W-1:0]   skid_pc;
    logic [DATA_W-1:0] skid_instr;

    // Trap has priority over a branch issued in the same cycle.
    assign redirect    = trap_take | branch_take;
    assign target      = word_align(trap_take ? trap_pc : branch_pc);

    // A response only counts while waiting, so stale data after reset is dropped.
    assign rsp_in_wait = (state_reg == IFU_WAIT) & ibus_rvalid;
    assign rsp_live    = rsp_in_wait & ~kill_reg & ~redirect;
    assign deliver     = rsp_live & ~if_stall;
    assign skid_load   = rsp_live & if_stall;
    assign skid_drain  = skid_valid & ~if_stall & ~redirect;

    assign ibus_req    = ~rst & ~redirect & ~if_stall & ~skid_valid
                       & ((state_reg == IFU_REQ) | rsp_in_wait);
    assign ibus_addr   = pc_reg;
    assign handshake   = ibus_req & ibus_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IFU_REQ;
            pc_reg          <= RESET_VECTOR;
            req_pc_reg      <= RESET_VECTOR;
            kill_reg        <= 1'b0;
            if2id_valid_reg <= 1'b0;
            if2id_pc_reg    <= '0;
            if2id_instr_reg <= '0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            req_pc_reg      <= req_pc_next;
            kill_reg        <= kill_next;
            if2id_valid_reg <= if2id_valid_next;
            if2id_pc_reg    <= if2id_pc_next;
            if2id_instr_reg <= if2id_instr_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        req_pc_next = req_pc_reg;
        kill_next   = kill_reg;
        if (redirect) begin
            pc_next = target;
            // A request still in flight must be swallowed when it returns.
            if ((state_reg == IFU_WAIT) && !ibus_rvalid) begin
                kill_next  = 1'b1;
                state_next = IFU_WAIT;
            end else begin
                kill_next  = 1'b0;
                state_next = IFU_REQ;
            end
        end else begin
            if (rsp_in_wait) begin
                kill_next = 1'b0;
            end
            if (handshake) begin
                req_pc_next = pc_reg;
                pc_next     = pc_reg + PC_STEP;
                state_next  = IFU_WAIT;
            end else if (rsp_in_wait) begin
                state_next  = IFU_REQ;
            end
        end
    end

    always_comb begin
        if2id_valid_next = if2id_valid_reg;
        if2id_pc_next    = if2id_pc_reg;
        if2id_instr_next = if2id_instr_reg;
        if (redirect) begin
            if2id_valid_next = 1'b0;
        end else if (!if_stall) begin
            if (deliver) begin
                if2id_valid_next = 1'b1;
                if2id_pc_next    = req_pc_reg;
                if2id_instr_next = ibus_rdata;
            end else if (skid_valid) begin
                if2id_valid_next = 1'b1;
                if2id_pc_next    = skid_pc;
                if2id_instr_next = skid_instr;
            end else begin
                if2id_valid_next = 1'b0;
            end
        end
    end

    ifu_skid_buf u_skid (
        .clk        (clk),
        .rst        (rst),
        .clear      (redirect),
        .load       (skid_load),
        .drain      (skid_drain),
        .load_pc    (req_pc_reg),
        .load_instr (ibus_rdata),
        .valid      (skid_valid),
        .pc         (skid_pc),
        .instr      (skid_instr)
    );

    assign if2id_valid       = if2id_valid_reg;
    assign if2id_pc          = if2id_pc_reg;
    assign if2id_instruction = if2id_instr_reg;

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: transaction-level model (expected fetch address stream and
// ordered delivery queue) plus directed cycle-exact expectations.
module tb_ifu;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_stall, branch_take, trap_take;
    logic [31:0] branch_pc, trap_pc;
    logic        ibus_req, ibus_ready, ibus_rvalid;
    logic [31:0] ibus_addr, ibus_rdata;
    logic        if2id_valid;
    logic [31:0] if2id_pc, if2id_instruction;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifu #(.RESET_VECTOR(RV)) dut (
        .clk               (clk),
        .rst               (rst),
        .if_stall          (if_stall),
        .branch_take       (branch_take),
        .branch_pc         (branch_pc),
        .trap_take         (trap_take),
        .trap_pc           (trap_pc),
        .ibus_req          (ibus_req),
        .ibus_addr         (ibus_addr),
        .ibus_ready        (ibus_ready),
        .ibus_rvalid       (ibus_rvalid),
        .ibus_rdata        (ibus_rdata),
        .if2id_valid       (if2id_valid),
        .if2id_pc          (if2id_pc),
        .if2id_instruction (if2id_instruction)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Model state: where the next fetch must go, whether the outstanding
    // request is still wanted, and the in-order list of instructions decode owes.
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_in_q[$];
    logic        mdl_live = 1'b0;
    logic [31:0] mdl_pend = 32'h0;
    logic [31:0] mdl_next = RV;
    logic        mon_hs = 1'b0;
    logic [31:0] mon_addr = 32'h0;
    logic        prev_hold = 1'b0;
    logic        prev_redir = 1'b0;
    logic        prev_v = 1'b0;
    logic [31:0] prev_pc = 32'h0;
    logic [31:0] prev_in = 32'h0;
    int          consumed = 0;

    always @(negedge clk) begin
        logic        redir;
        logic [31:0] tgt;
        redir  = branch_take | trap_take;
        tgt    = (trap_take ? trap_pc : branch_pc) & 32'hFFFF_FFFC;
        mon_hs = 1'b0;
        if (rst) begin
            chk("req_in_reset", ibus_req, 0);
            exp_pc_q.delete();
            exp_in_q.delete();
            mdl_live   = 1'b0;
            mdl_next   = RV;
            prev_hold  = 1'b0;
            prev_redir = 1'b0;
        end else begin
            if (prev_redir) chk("valid_after_redirect", if2id_valid, 0);
            if (prev_hold) begin
                chk("hold_valid", if2id_valid, prev_v);
                chk("hold_pc", if2id_pc, prev_pc);
                chk("hold_instr", if2id_instruction, prev_in);
            end
            if (redir || if_stall) chk("req_suppressed", ibus_req, 0);
            if (ibus_req) chk("addr_aligned", ibus_addr[1:0], 0);
            if (if2id_valid && !if_stall && !redir) begin
                if (exp_pc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL id_unexpected: got pc %08h expected no instruction", if2id_pc);
                end else begin
                    chk("id_pc", if2id_pc, exp_pc_q.pop_front());
                    chk("id_instr", if2id_instruction, exp_in_q.pop_front());
                    consumed++;
                    $display("decode pc=%08h instr=%08h", if2id_pc, if2id_instruction);
                end
            end
            if (ibus_rvalid && mdl_live) begin
                if (!redir) begin
                    exp_pc_q.push_back(mdl_pend);
                    exp_in_q.push_back(instr_of(mdl_pend));
                end
                mdl_live = 1'b0;
            end
            if (redir) begin
                exp_pc_q.delete();
                exp_in_q.delete();
                mdl_live = 1'b0;
                mdl_next = tgt;
            end
            if (ibus_req && ibus_ready) begin
                chk("fetch_addr", ibus_addr, mdl_next);
                mdl_pend = mdl_next;
                mdl_live = 1'b1;
                mdl_next = mdl_next + 32'd4;
                mon_hs   = 1'b1;
                mon_addr = ibus_addr;
                $display("fetch addr=%08h", ibus_addr);
            end
            prev_hold  = if_stall && !redir;
            prev_redir = redir;
        end
        prev_v  = if2id_valid;
        prev_pc = if2id_pc;
        prev_in = if2id_instruction;
    end

    // Instruction memory: answers each accepted request mem_lat cycles later.
    int          mem_lat = 1;
    logic        mem_pend;
    logic [31:0] mem_addr;
    int          mem_cnt;

    initial begin
        ibus_rvalid = 1'b0;
        ibus_rdata  = 32'h0;
        mem_pend    = 1'b0;
        mem_addr    = 32'h0;
        mem_cnt     = 0;
        forever begin
            @(posedge clk);
            #2;
            ibus_rvalid = 1'b0;
            if (mon_hs) begin
                mem_pend = 1'b1;
                mem_addr = mon_addr;
                mem_cnt  = mem_lat;
            end
            if (mem_pend) begin
                mem_cnt--;
                if (mem_cnt <= 0) begin
                    ibus_rvalid = 1'b1;
                    ibus_rdata  = instr_of(mem_addr);
                    mem_pend    = 1'b0;
                end
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    logic [39:0] pat_r = 40'b1101_1110_1011_1111_0110_1111_1010_1101_1111_0111;
    logic [39:0] pat_s = 40'b0001_1000_0110_0000_1100_0010_0000_0111_0000_1000;

    initial begin
        if_stall    = 1'b0;
        branch_take = 1'b0;
        trap_take   = 1'b0;
        branch_pc   = 32'h0;
        trap_pc     = 32'h0;
        ibus_ready  = 1'b1;
        repeat (3) nxt();
        mid(); chk("reset_valid", if2id_valid, 0);

        nxt(); rst = 1'b0;                                   // c0
        mid(); chk("c0_req", ibus_req, 1); chk("c0_addr", ibus_addr, RV); chk("c0_valid", if2id_valid, 0);
        nxt();                                               // c1
        mid(); chk("c1_valid", if2id_valid, 0); chk("c1_addr", ibus_addr, 32'h4);
        nxt();                                               // c2
        mid(); chk("c2_valid", if2id_valid, 1); chk("c2_pc", if2id_pc, 32'h0);
               chk("c2_instr", if2id_instruction, instr_of(32'h0)); chk("c2_addr", ibus_addr, 32'h8);
        nxt(); if_stall = 1'b1;                              // c3: response for 0x8 arrives
        mid(); chk("c3_pc", if2id_pc, 32'h4); chk("c3_req", ibus_req, 0); chk("c3_addr", ibus_addr, 32'hC);
        nxt();                                               // c4
        mid(); chk("c4_pc", if2id_pc, 32'h4); chk("c4_valid", if2id_valid, 1); chk("c4_req", ibus_req, 0);
        nxt();                                               // c5
        mid(); chk("c5_pc", if2id_pc, 32'h4); chk("c5_req", ibus_req, 0);
        nxt(); if_stall = 1'b0;                              // c6: skid drains
        mid(); chk("c6_pc", if2id_pc, 32'h4); chk("c6_req", ibus_req, 0);
        nxt();                                               // c7
        mid(); chk("c7_pc", if2id_pc, 32'h8); chk("c7_req", ibus_req, 1); chk("c7_addr", ibus_addr, 32'hC);
        nxt();                                               // c8: request 0x10 issued
        mid(); chk("c8_valid", if2id_valid, 0); chk("c8_addr", ibus_addr, 32'h10);
        nxt(); mem_lat = 3; branch_take = 1'b1; branch_pc = 32'h100;  // c9
        mid(); chk("c9_pc", if2id_pc, 32'hC); chk("c9_req", ibus_req, 0);
        nxt(); branch_take = 1'b0; mem_lat = 1;              // c10
        mid(); chk("c10_valid", if2id_valid, 0); chk("c10_req", ibus_req, 0); chk("c10_addr", ibus_addr, 32'h100);
        nxt();                                               // c11: killed response
        mid(); chk("c11_req", ibus_req, 1); chk("c11_addr", ibus_addr, 32'h100); chk("c11_valid", if2id_valid, 0);
        nxt();                                               // c12
        mid(); chk("c12_valid", if2id_valid, 0);
        nxt(); trap_take = 1'b1; trap_pc = 32'h200; branch_take = 1'b1; branch_pc = 32'h100;  // c13
        mid(); chk("c13_pc", if2id_pc, 32'h100); chk("c13_instr", if2id_instruction, instr_of(32'h100));
               chk("c13_req", ibus_req, 0);
        nxt(); trap_take = 1'b0; branch_take = 1'b0;         // c14
        mid(); chk("c14_req", ibus_req, 1); chk("c14_addr", ibus_addr, 32'h200); chk("c14_valid", if2id_valid, 0);
        nxt();                                               // c15
        nxt(); if_stall = 1'b1; branch_take = 1'b1; branch_pc = 32'h100;  // c16: redirect + rvalid + stall
        mid(); chk("c16_pc", if2id_pc, 32'h200); chk("c16_req", ibus_req, 0);
        nxt(); if_stall = 1'b0; branch_take = 1'b0;          // c17
        mid(); chk("c17_valid", if2id_valid, 0); chk("c17_req", ibus_req, 1); chk("c17_addr", ibus_addr, 32'h100);
        nxt();                                               // c18
        nxt(); branch_take = 1'b1; branch_pc = 32'hFFFF_FFFE;  // c19
        mid(); chk("c19_pc", if2id_pc, 32'h100);
        nxt(); branch_take = 1'b0;                           // c20
        mid(); chk("c20_addr", ibus_addr, 32'hFFFF_FFFC); chk("c20_req", ibus_req, 1);
        nxt();                                               // c21
        mid(); chk("c21_addr", ibus_addr, 32'h0); chk("c21_req", ibus_req, 1);
        nxt();                                               // c22
        mid(); chk("c22_pc", if2id_pc, 32'hFFFF_FFFC); chk("c22_valid", if2id_valid, 1);
        nxt();                                               // c23
        mid(); chk("c23_pc", if2id_pc, 32'h0); chk("c23_addr", ibus_addr, 32'h8);
        nxt(); rst = 1'b1; mem_lat = 2;                      // c24: reset mid-WAIT
        nxt(); rst = 1'b0; mem_lat = 1;                      // c25: stale response arrives
        mid(); chk("c25_valid", if2id_valid, 0); chk("c25_req", ibus_req, 1); chk("c25_addr", ibus_addr, RV);
        nxt();                                               // c26
        mid(); chk("c26_valid", if2id_valid, 0);
        nxt();                                               // c27
        mid(); chk("c27_valid", if2id_valid, 1); chk("c27_pc", if2id_pc, RV);
               chk("c27_instr", if2id_instruction, instr_of(RV));

        for (int i = 0; i < 40; i++) begin
            nxt();
            ibus_ready = pat_r[i];
            if_stall   = pat_s[i];
        end
        nxt(); ibus_ready = 1'b0; if_stall = 1'b0;
        repeat (6) nxt();
        mid();
        chk("drain_queue_empty", exp_pc_q.size(), 0);
        chk("drain_idle", if2id_valid, 0);
        chk("drain_consumed_some", (consumed >= 20) ? 32'd1 : 32'd0, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/ifu.md
Name: ifu

Overview:
Instruction fetch unit. It is the producer side of the IF/ID pipe and drives if2id_valid, if2id_pc and if2id_instruction into the decode stage. It owns the fetch PC and issues requests on a simple req/ready + rvalid instruction bus, with at most one request outstanding. It absorbs decode back-pressure through a 1-entry skid buffer and handles branch and trap redirects, including killing an in-flight response.

Parameters:
RESET_VECTOR, 32'h0000_0000, first fetch address after reset.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
if_stall  in  1  from HDU; decode cannot accept, hold IF/ID register
branch_take  in  1  redirect from EX (taken branch/jal/jalr)
branch_pc  in  32  branch target
trap_take  in  1  redirect from trap/mret logic
trap_pc  in  32  trap/mret target
ibus_req  out  1  fetch request valid
ibus_addr  out  32  fetch address; bits [1:0] always 0
ibus_ready  in  1  request accepted when ibus_req & ibus_ready
ibus_rvalid  in  1  response valid, one cycle per accepted request, in order
ibus_rdata  in  32  instruction word
if2id_valid  out  1  IF/ID register valid
if2id_pc  out  32  PC of if2id_instruction
if2id_instruction  out  32  fetched instruction

Behaviour:
- Reset (clk edge with rst=1):
  - pc <= RESET_VECTOR; state <= REQ.
  - if2id_valid <= 0; skid_valid <= 0; kill <= 0.
  - ibus_req is forced to 0 while rst=1.
  - ibus_rvalid is ignored unless state=WAIT, so a reset mid-transaction leaves no stale data.
- Redirect:
  - redirect = trap_take | branch_take; target = trap_take ? trap_pc : branch_pc (trap wins).
  - target[1:0] are ignored (forced 0). Misalignment is checked in EX.
- Issue:
  - ibus_req = ~rst & ~redirect & ~if_stall & ~skid_valid & (state==REQ | (state==WAIT & ibus_rvalid)).
  - ibus_addr = pc. The address may change while unaccepted, on redirect.
- FSM, two states:
  - REQ: on handshake, req_pc <= pc, pc <= pc+4, go to WAIT.
  - WAIT: on ibus_rvalid, consume the response. If a handshake also occurs in the same cycle (back-to-back issue), stay in WAIT; otherwise go to REQ.
  - Zero-wait memory sustains 1 instruction/cycle.
- Response delivery (rvalid in WAIT, kill=0, no redirect):
  - if_stall=0: if2id_valid/pc/instruction <= 1 / req_pc / ibus_rdata.
  - if_stall=1: the IF/ID register holds; {req_pc, ibus_rdata} is written to the skid buffer, skid_valid <= 1.
- Skid drain:
  - When skid_valid & ~if_stall & ~redirect: IF/ID <= skid contents, skid_valid <= 0.
  - No request is outstanding while skid_valid=1, so a drain never collides with rvalid.
- Idle cycle (~if_stall, no response, skid empty): if2id_valid <= 0.
- if_stall=1 holds if2id_valid, if2id_pc and if2id_instruction bit-stable.
- Redirect cycle (overrides stall):
  - pc <= target; if2id_valid <= 0; skid_valid <= 0.
  - If state==WAIT & ~ibus_rvalid: kill <= 1 and stay in WAIT.
  - If state==WAIT & ibus_rvalid: the response is dropped; go to REQ.
  - No request is issued in the redirect cycle.
  - The first target request is issued the next cycle, or when the killed response arrives.
- Killed response: rvalid with kill=1 is discarded; kill <= 0.
- Wrap-around: pc+4 wraps modulo 2^32, with no flag.
- Simultaneous if_stall & redirect: redirect behaviour applies; the stall only suppresses issue.
- Latency: the first instruction after reset or redirect reaches if2id_valid two cycles after its handshake when ready=1 and the response arrives the next cycle.

Decomposition:
- Core package/header:
  - RESET_VECTOR default.
  - IFU state encoding (IFU_REQ, IFU_WAIT).
  - Instruction bus width constants, reusing the existing PC/DATA ranges.
- Sub-module: ifu_skid_buf. A 1-entry {pc, instr} holding register with load/drain/clear and a valid flag.

Test Plan:
- Reset, then ready=1 with rvalid the cycle after each handshake → ibus_addr 0,4,8,C; if2id_pc 0,4,8 on consecutive cycles, if2id_valid=1 from the 2nd cycle after the first handshake.
- if_stall=1 for 3 cycles while the response for 0x8 arrives → if2id holds pc 0x4; skid holds 0x8; ibus_req=0; after release, if2id_pc=0x8 then 0xC with no loss or duplicate.
- branch_take with branch_pc=0x100 while a request for 0x10 is in WAIT, rvalid 2 cycles later → the 0x10 response is dropped, if2id_valid=0, next ibus_addr=0x100, if2id_pc=0x100.
- trap_take (trap_pc=0x200) and branch_take (branch_pc=0x100) in the same cycle → next fetch 0x200; no instruction from 0x100 appears.
- Redirect coincident with rvalid and if_stall=1 → the response is dropped, skid stays empty, if2id_valid=0, next request 0x100.
- pc=0xFFFF_FFFC fetched → next ibus_addr=0x0000_0000; rst asserted mid-WAIT → if2id_valid=0, first post-reset ibus_addr=RESET_VECTOR.
